// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states and port owner.
package mem_arb_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable down-counter timing the memory access latency; done_c flags a zero count.
module mem_arb_lat_cnt #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic clk,
  input  logic reset_in,
  input  logic load,
  input  logic dec,
  output logic done_c
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(MEM_LAT - 1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done_c = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch (I) and load/store (D) requesters onto one fixed-latency memory port.
// Optional ARB_ROUND_ROBIN_EN: alternate conflict winner; otherwise D always wins a conflict.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (MEM_LAT < 1) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be at least 1");
  end

  state_t state, state_nxt;
  owner_t owner, win_c;
  logic   take_c, load_c, done_c, cmd_we;
`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_owner;
`endif

  // Conflict resolution: D is the older instruction unless round-robin is enabled.
  always_comb begin
    win_c = d_req ? OWN_D : OWN_I;
`ifdef ARB_ROUND_ROBIN_EN
    if (i_req && d_req) win_c = (last_owner == OWN_I) ? OWN_D : OWN_I;
`endif
  end

  always_comb begin
    state_nxt = state;
    take_c    = 1'b0;
    load_c    = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          state_nxt = ISSUE;
          take_c    = 1'b1;
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
        load_c    = 1'b1;
      end
      WAIT: begin
        if (done_c) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  mem_arb_lat_cnt #(.MEM_LAT(MEM_LAT)) u_lat_cnt (
    .clk      (clk),
    .reset_in (reset_in),
    .load     (load_c),
    .dec      (state == WAIT),
    .done_c   (done_c)
  );

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state      <= IDLE;
      owner      <= OWN_I;
      cmd_we     <= 1'b0;
      busy       <= 1'b0;
      i_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      i_rvalid   <= 1'b0;
      d_rvalid   <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner <= OWN_I;
`endif
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != IDLE);
      i_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      mem_en   <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      if (take_c) begin
        owner     <= win_c;
        cmd_we    <= (win_c == OWN_D) && d_we;
        mem_we    <= (win_c == OWN_D) && d_we;
        mem_addr  <= (win_c == OWN_D) ? d_addr : i_addr;
        mem_wdata <= (win_c == OWN_D) ? d_wdata : '0;
        mem_en    <= 1'b1;
        i_gnt     <= (win_c == OWN_I);
        d_gnt     <= (win_c == OWN_D);
`ifdef ARB_ROUND_ROBIN_EN
        last_owner <= win_c;
`endif
      end
      if (load_c) mem_we <= 1'b0;
      if ((state == WAIT) && done_c) begin
        if (owner == OWN_I) begin
          i_rdata  <= mem_rdata;
          i_rvalid <= 1'b1;
        end else begin
          d_rvalid <= 1'b1;
          if (!cmd_we) d_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a cycle-level transaction model predicts grants and responses.
module tb_mem_port_arbiter;

  parameter int unsigned MEM_LAT = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset_in = 1'b1;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset_in(reset_in),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { int cyc; bit own_d; bit we; logic [31:0] addr; logic [31:0] wdata; } gnt_exp_t;
  typedef struct { int cyc; bit own_d; bit we; logic [31:0] data; } rsp_exp_t;

  gnt_exp_t gq[$];
  rsp_exp_t rq[$];
  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          free_at = 0, busy_lo = 0;
  bit          last_d = 1'b0;
  logic [31:0] hold_i = '0, hold_d = '0;

  function automatic logic [31:0] seed_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] env_read(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : seed_word(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_word(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Memory environment: correct word only in the last latency cycle, inverted garbage before.
  int wcyc;
  always @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      wcyc      <= 0;
      mem_rdata <= '0;
    end else begin
      wcyc      <= mem_en ? 1 : ((wcyc != 0 && wcyc < int'(MEM_LAT)) ? wcyc + 1 : 0);
      mem_rdata <= ((mem_en ? 1 : ((wcyc != 0 && wcyc < int'(MEM_LAT)) ? wcyc + 1 : 0)) == int'(MEM_LAT))
                   ? env_read(mem_addr) : ~env_read(mem_addr);
    end
  end

  always @(posedge clk) begin
    if (reset_in && mem_en && mem_we) env_mem[mem_addr] = mem_wdata;
  end

  // Reference model: one transaction at a time, gnt next cycle, response MEM_LAT+1 after gnt.
  gnt_exp_t ge;
  rsp_exp_t re;
  bit       wd;
  always @(posedge clk) begin
    if (reset_in && free_at <= cyc && (i_req || d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
      wd = (i_req && d_req) ? !last_d : d_req;
`else
      wd = d_req;
`endif
      last_d   = wd;
      ge.cyc   = cyc + 1;
      ge.own_d = wd;
      ge.we    = wd && d_we;
      ge.addr  = wd ? d_addr : i_addr;
      ge.wdata = d_wdata;
      re.cyc   = cyc + 2 + int'(MEM_LAT);
      re.own_d = wd;
      re.we    = ge.we;
      re.data  = ge.we ? 32'h0 : ref_read(ge.addr);
      if (ge.we) ref_mem[ge.addr] = ge.wdata;
      gq.push_back(ge);
      rq.push_back(re);
      busy_lo = ge.cyc;
      free_at = re.cyc;
    end
    cyc = cyc + 1;
  end

  // Monitor: pops expectations whenever the DUT presents a grant or a response.
  gnt_exp_t mg;
  rsp_exp_t mr;
  always @(negedge clk) begin
    if (reset_in) begin
      if (i_gnt && d_gnt) chk("two_gnt", 32'(1), 32'(0));
      if (i_rvalid && d_rvalid) chk("two_rvalid", 32'(1), 32'(0));
      if (i_gnt || d_gnt) begin
        if (gq.size() == 0) chk("gnt_unexpected", 32'(1), 32'(0));
        else begin
          mg = gq.pop_front();
          chk("gnt_cycle", 32'(cyc), 32'(mg.cyc));
          chk("gnt_owner_d", 32'(d_gnt), 32'(mg.own_d));
          chk("mem_en", 32'(mem_en), 32'(1));
          chk("mem_we", 32'(mem_we), 32'(mg.we));
          chk("mem_addr", mem_addr, mg.addr);
          if (mg.we) chk("mem_wdata", mem_wdata, mg.wdata);
        end
      end else begin
        if (mem_en) chk("mem_en_no_gnt", 32'(1), 32'(0));
        if (gq.size() > 0 && gq[0].cyc <= cyc) begin
          chk("gnt_missing", 32'(0), 32'(1));
          void'(gq.pop_front());
        end
      end
      if (i_rvalid || d_rvalid) begin
        if (rq.size() == 0) chk("rvalid_unexpected", 32'(1), 32'(0));
        else begin
          mr = rq.pop_front();
          chk("rvalid_cycle", 32'(cyc), 32'(mr.cyc));
          chk("rvalid_owner_d", 32'(d_rvalid), 32'(mr.own_d));
          if (!mr.own_d) hold_i = mr.data;
          else if (!mr.we) hold_d = mr.data;
        end
      end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
        chk("rvalid_missing", 32'(0), 32'(1));
        void'(rq.pop_front());
      end
      chk("i_rdata", i_rdata, hold_i);
      chk("d_rdata", d_rdata, hold_d);
      chk("busy", 32'(busy), 32'(cyc >= busy_lo && cyc < free_at));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_gnt_i(input string name);
    int g = 0;
    while (!i_gnt && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) chk(name, 32'(0), 32'(1));
    i_req = 1'b0;
  endtask

  task automatic wait_gnt_d(input string name);
    int g = 0;
    while (!d_gnt && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) chk(name, 32'(0), 32'(1));
    d_req = 1'b0;
  endtask

  // Both sides request together; each side is held until it has n_hold grants of the run.
  task automatic conflict_run(input int n_hold, output bit o[8], output int tg[8], output int k);
    int guard = 0;
    k = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    i_req = 1'b1; i_addr = 32'h24;
    while ((i_req || d_req) && guard < 200) begin
      @(negedge clk);
      guard++;
      if (i_gnt || d_gnt) begin
        if (k < 8) begin o[k] = d_gnt; tg[k] = cyc; end
        k++;
        if (k >= n_hold) begin
          if (i_gnt) i_req = 1'b0;
          if (d_gnt) d_req = 1'b0;
        end
      end
    end
    if (guard >= 200) chk("conflict_timeout", 32'(0), 32'(1));
  endtask

  task automatic stim_cycle(input bit allow_new);
    @(negedge clk);
    if (i_gnt) i_req = 1'b0;
    if (d_gnt) d_req = 1'b0;
    if (allow_new && !i_req && $urandom_range(0, 2) == 0) begin
      i_req  = 1'b1;
      i_addr = 32'($urandom_range(0, 15)) << 2;
    end
    if (allow_new && !d_req && $urandom_range(0, 2) == 0) begin
      d_req   = 1'b1;
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = 32'($urandom_range(0, 15)) << 2;
      d_wdata = $urandom;
    end
  endtask

  bit o[8];
  int tg[8];
  int nk;
  initial begin
    env_mem[32'h40] = 32'h8C020004;
    ref_mem[32'h40] = 32'h8C020004;
    #1 reset_in = 1'b0;
    idle(3);
    chk("reset_outputs", 32'(|{i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
                               mem_en, mem_we, mem_addr, mem_wdata, busy}), 32'(0));
    reset_in = 1'b1;
    idle(2);

    // Lone fetch of a known word
    i_req = 1'b1; i_addr = 32'h40;
    wait_gnt_i("fetch_gnt_timeout");
    idle(int'(MEM_LAT) + 1);
    chk("fetch_rdata", i_rdata, 32'h8C020004);
    idle(2);

    // Store of a known word
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
    wait_gnt_d("store_gnt_timeout");
    idle(int'(MEM_LAT) + 3);
    chk("store_mem", env_read(32'h10), 32'hDEADBEEF);

    // Simultaneous requests, each dropped once granted
    conflict_run(1, o, tg, nk);
    chk("conflict_count", 32'(nk), 32'(2));
    chk("conflict_gap", 32'(tg[1] - tg[0]), 32'(MEM_LAT + 2));
`ifndef ARB_ROUND_ROBIN_EN
    chk("conflict_first_d", 32'(o[0]), 32'(1));
`endif
    idle(int'(MEM_LAT) + 3);

    // Both held across four grants
    conflict_run(4, o, tg, nk);
    for (int k = 1; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      chk("rr_alternate", 32'(o[k] ^ o[k-1]), 32'(1));
`else
      chk("prio_d_wins", 32'(o[k]), 32'(1));
`endif
      chk("held_gap", 32'(tg[k] - tg[k-1]), 32'(MEM_LAT + 2));
    end
    idle(int'(MEM_LAT) + 3);

    // Randomized traffic, then let pending requests drain
    for (int n = 0; n < 800; n++) stim_cycle(1'b1);
    for (int n = 0; n < 40 && (i_req || d_req); n++) stim_cycle(1'b0);
    chk("drain_reqs", 32'(i_req || d_req), 32'(0));
    idle(int'(MEM_LAT) + 4);
    chk("queues_empty", 32'(gq.size() + rq.size()), 32'(0));

    // Reset in the middle of a WAIT phase aborts the access
    i_req = 1'b1; i_addr = 32'h40;
    wait_gnt_i("abort_gnt_timeout");
    @(negedge clk);
    #2 reset_in = 1'b0;
    gq.delete(); rq.delete();
    free_at = 0; busy_lo = 0; last_d = 1'b0; hold_i = '0; hold_d = '0;
    #1 chk("abort_outputs", 32'(|{i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
                                mem_en, mem_we, mem_addr, mem_wdata, busy}), 32'(0));
    idle(2);
    reset_in = 1'b1;
    for (int n = 0; n < int'(MEM_LAT) + 6; n++) begin
      @(negedge clk);
      chk("abort_no_rvalid", 32'(i_rvalid || d_rvalid), 32'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
